// File: rtl/booth_mul_sequencer_if.sv
// Handshake and data bundle between the control unit and the Booth multiplier.
// The control unit is the master: it drives start/operands and reads
// busy/done/hi/lo. The sequencer is the slave.
interface booth_mul_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/booth_mul_sequencer.sv
// Multi-cycle signed Booth multiplier sequencer for the ALU MUL path.
// One Booth step per clock through a shared adder and a {A, Q, q_minus1}
// shift register. IDLE -> RUN -> DONE; all outputs are registered.
// Optional build macro BOOTH_RADIX4_EN selects modified Booth radix-4
// (two multiplier bits per step, WIDTH/2 steps); the default build is radix-2.
module booth_mul_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clock,
  input  logic                 clear_n,
  booth_mul_sequencer_if.slave bus
);

`ifdef BOOTH_RADIX4_EN
  // Two guard bits: A +/- 2M must not overflow the accumulator.
  localparam int AW    = WIDTH + 2;
  localparam int SH    = 2;
  localparam int STEPS = WIDTH / 2;
`else
  // One guard bit: M = -2^(WIDTH-1) can be negated without overflow.
  localparam int AW    = WIDTH + 1;
  localparam int SH    = 1;
  localparam int STEPS = WIDTH;
`endif

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic signed [AW-1:0]    a_q, a_d;
  logic signed [AW-1:0]    m_q, m_d;
  logic        [WIDTH-1:0] qreg_q, qreg_d;
  logic                    qm1_q, qm1_d;
  logic        [CNT_W-1:0] cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic        [WIDTH-1:0] hi_q, hi_d;
  logic        [WIDTH-1:0] lo_q, lo_d;

  // One Booth step: recode, add, then arithmetic shift of {A, Q, q_minus1}.
  logic signed [AW-1:0]       sum;
  logic signed [AW+WIDTH:0]   shifted;
  logic signed [AW-1:0]       a_nxt;
  logic        [WIDTH-1:0]    q_nxt;
  logic                       qm1_nxt;

  // Shared adder fed by the Booth recoding of the low multiplier bits.
  always_comb begin
    sum = a_q;
`ifdef BOOTH_RADIX4_EN
    case ({qreg_q[1:0], qm1_q})
      3'b001, 3'b010: sum = a_q + m_q;
      3'b011:         sum = a_q + (m_q <<< 1);
      3'b100:         sum = a_q - (m_q <<< 1);
      3'b101, 3'b110: sum = a_q - m_q;
      default:        sum = a_q;
    endcase
`else
    case ({qreg_q[0], qm1_q})
      2'b10:   sum = a_q - m_q;
      2'b01:   sum = a_q + m_q;
      default: sum = a_q;
    endcase
`endif
    shifted = $signed({sum, qreg_q, qm1_q}) >>> SH;
    a_nxt   = shifted[AW+WIDTH:WIDTH+1];
    q_nxt   = shifted[WIDTH:1];
    qm1_nxt = shifted[0];
  end

  // Next-state and register-update decisions for the sequencer.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    qreg_d  = qreg_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          a_d     = '0;
          m_d     = {{(AW-WIDTH){bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
          qreg_d  = bus.multiplier;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        a_d    = a_nxt;
        qreg_d = q_nxt;
        qm1_d  = qm1_nxt;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          hi_d    = a_nxt[WIDTH-1:0];
          lo_d    = q_nxt;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; clear_n wipes everything, including hi/lo.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      m_q     <= '0;
      qreg_q  <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      qreg_q  <= qreg_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_booth_mul_sequencer.sv
// Self-checking bench for booth_mul_sequencer (WIDTH=32). Expected products
// come from plain signed 64-bit multiplication of the accepted operands.
module tb_booth_mul_sequencer;

`ifdef BOOTH_RADIX4_EN
  localparam int LAT = 16;
`else
  localparam int LAT = 32;
`endif

  logic clk;
  logic clear_n;
  int   n_cmp;
  int   n_bad;

  booth_mul_sequencer_if #(.WIDTH(32)) bif ();

  booth_mul_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clock   (clk),
    .clear_n (clear_n),
    .bus     (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [31:0] m, input logic [31:0] q);
    longint p;
    p = longint'($signed(m)) * longint'($signed(q));
    return 64'(p);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start with the given operands and wait (bounded) for done.
  // edges = clock edges from the accepting edge to done becoming visible.
  task automatic launch_and_wait(input logic [31:0] m, input logic [31:0] q, input bit noise,
                                 output int edges, output bit busy_ok, output bit stable_ok,
                                 output logic [31:0] hi, output logic [31:0] lo);
    logic [31:0] h0, l0;
    h0 = bif.hi;
    l0 = bif.lo;
    bif.multiplicand = m;
    bif.multiplier   = q;
    bif.start        = 1'b1;
    tick();
    bif.start = 1'b0;
    edges = 0;
    busy_ok = 1'b1;
    stable_ok = 1'b1;
    while (bif.done !== 1'b1 && edges < LAT + 20) begin
      if (bif.busy !== 1'b1) busy_ok = 1'b0;
      if (bif.hi !== h0 || bif.lo !== l0) stable_ok = 1'b0;
      if (noise) begin
        bif.start        = 1'($urandom);
        bif.multiplicand = $urandom;
        bif.multiplier   = $urandom;
      end
      tick();
      edges++;
    end
    if (bif.busy !== 1'b0) busy_ok = 1'b0;
    bif.start = 1'b0;
    hi = bif.hi;
    lo = bif.lo;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (bif.done !== 1'b1 && edges < LAT + 20) begin
      tick();
      edges++;
    end
  endtask

  task automatic test_reset();
    bif.start = 1'b1;
    bif.multiplicand = 32'd1;
    bif.multiplier = 32'd1;
    clear_n = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (bif.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bif.busy); end
    n_cmp++;
    if (bif.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bif.done); end
    n_cmp++;
    if (bif.hi !== 32'd0) begin n_bad++; $display("FAIL reset_hi: got %h want 0", bif.hi); end
    n_cmp++;
    if (bif.lo !== 32'd0) begin n_bad++; $display("FAIL reset_lo: got %h want 0", bif.lo); end
    // start already high while in reset: accepted on the first edge out of reset
    clear_n = 1'b1;
    tick();
    bif.start = 1'b0;
    n_cmp++;
    if (bif.busy !== 1'b1) begin n_bad++; $display("FAIL reset_release_accept: busy got %b want 1", bif.busy); end
    begin
      int e;
      wait_done(e);
      n_cmp++;
      if (bif.lo !== 32'd1 || bif.hi !== 32'd0) begin
        n_bad++; $display("FAIL reset_release_product: got %h_%h want 0_1", bif.hi, bif.lo);
      end
    end
    repeat (2) tick();
  endtask

  task automatic test_directed();
    logic [31:0] tm [0:3];
    logic [31:0] tq [0:3];
    int e;
    bit bok, sok;
    logic [31:0] h, l;
    tm[0] = 32'd7;        tq[0] = 32'hFFFFFFFD;
    tm[1] = 32'h80000000; tq[1] = 32'h80000000;
    tm[2] = 32'hFFFFFFFF; tq[2] = 32'hFFFFFFFF;
    tm[3] = 32'h12345678; tq[3] = 32'd0;
    for (int i = 0; i < 4; i++) begin
      launch_and_wait(tm[i], tq[i], 1'b0, e, bok, sok, h, l);
      n_cmp++;
      if (e !== LAT) begin n_bad++; $display("FAIL dir%0d_latency: got %0d want %0d", i, e, LAT); end
      n_cmp++;
      if (bok !== 1'b1) begin n_bad++; $display("FAIL dir%0d_busy: got %b want 1", i, bok); end
      n_cmp++;
      if (sok !== 1'b1) begin n_bad++; $display("FAIL dir%0d_hilo_stable: got %b want 1", i, sok); end
      n_cmp++;
      if ({h, l} !== model(tm[i], tq[i])) begin
        n_bad++; $display("FAIL dir%0d_product: got %h_%h want %h", i, h, l, model(tm[i], tq[i]));
      end
      tick();
      n_cmp++;
      if (bif.done !== 1'b0) begin n_bad++; $display("FAIL dir%0d_done_pulse: got %b want 0", i, bif.done); end
      tick();
    end
    // spot-check the model against the hand-computed first case
    n_cmp++;
    if (model(tm[0], tq[0]) !== 64'hFFFFFFFF_FFFFFFEB) begin
      n_bad++; $display("FAIL model_7x-3: got %h want FFFFFFFFFFFFFFEB", model(tm[0], tq[0]));
    end
  endtask

  task automatic test_ignore_start();
    int e;
    bit bok, sok;
    logic [31:0] m, q, h, l;
    for (int i = 0; i < 4; i++) begin
      m = $urandom;
      q = $urandom;
      launch_and_wait(m, q, 1'b1, e, bok, sok, h, l);
      n_cmp++;
      if (e !== LAT) begin n_bad++; $display("FAIL ign%0d_latency: got %0d want %0d", i, e, LAT); end
      n_cmp++;
      if ({h, l} !== model(m, q)) begin
        n_bad++; $display("FAIL ign%0d_product: got %h_%h want %h", i, h, l, model(m, q));
      end
      repeat (2) tick();
    end
  endtask

  task automatic test_back_to_back();
    int e;
    bif.multiplicand = 32'd5;
    bif.multiplier   = 32'd6;
    bif.start        = 1'b1;
    tick();
    wait_done(e);
    n_cmp++;
    if (e !== LAT) begin n_bad++; $display("FAIL b2b_first_latency: got %0d want %0d", e, LAT); end
    n_cmp++;
    if ({bif.hi, bif.lo} !== model(32'd5, 32'd6)) begin
      n_bad++; $display("FAIL b2b_first_product: got %h_%h want %h", bif.hi, bif.lo, model(32'd5, 32'd6));
    end
    bif.multiplicand = -32'sd4;
    bif.multiplier   = 32'd9;
    tick();
    n_cmp++;
    if (bif.busy !== 1'b0 || bif.done !== 1'b0) begin
      n_bad++; $display("FAIL b2b_idle_gap: got busy=%b done=%b want 0 0", bif.busy, bif.done);
    end
    tick();
    n_cmp++;
    if (bif.busy !== 1'b1) begin n_bad++; $display("FAIL b2b_reaccept: busy got %b want 1", bif.busy); end
    bif.start = 1'b0;
    bif.multiplicand = $urandom;
    bif.multiplier   = $urandom;
    wait_done(e);
    n_cmp++;
    if (e !== LAT) begin n_bad++; $display("FAIL b2b_second_latency: got %0d want %0d", e, LAT); end
    n_cmp++;
    if ({bif.hi, bif.lo} !== 64'hFFFFFFFF_FFFFFFDC) begin
      n_bad++; $display("FAIL b2b_second_product: got %h_%h want FFFFFFFF_FFFFFFDC", bif.hi, bif.lo);
    end
    repeat (2) tick();
  endtask

  task automatic test_clear_mid();
    int e;
    bit bok, sok, seen;
    logic [31:0] h, l;
    bif.multiplicand = 32'd100;
    bif.multiplier   = 32'd100;
    bif.start        = 1'b1;
    tick();
    bif.start = 1'b0;
    repeat (9) tick();
    clear_n = 1'b0;
    tick();
    clear_n = 1'b1;
    n_cmp++;
    if (bif.busy !== 1'b0 || bif.done !== 1'b0) begin
      n_bad++; $display("FAIL clr_ctrl: got busy=%b done=%b want 0 0", bif.busy, bif.done);
    end
    n_cmp++;
    if (bif.hi !== 32'd0 || bif.lo !== 32'd0) begin
      n_bad++; $display("FAIL clr_hilo: got %h_%h want 0_0", bif.hi, bif.lo);
    end
    seen = 1'b0;
    repeat (LAT + 4) begin
      tick();
      if (bif.done === 1'b1 || bif.busy === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL clr_no_done: activity got %b want 0", seen); end
    launch_and_wait(32'd3, 32'd4, 1'b0, e, bok, sok, h, l);
    n_cmp++;
    if (e !== LAT) begin n_bad++; $display("FAIL clr_after_latency: got %0d want %0d", e, LAT); end
    n_cmp++;
    if ({h, l} !== 64'd12) begin n_bad++; $display("FAIL clr_after_product: got %h_%h want 0_C", h, l); end
    repeat (2) tick();
  endtask

  task automatic test_random();
    int e;
    bit bok, sok;
    logic [31:0] m, q, h, l;
    for (int i = 0; i < 16; i++) begin
      m = $urandom;
      q = $urandom;
      if (i % 4 == 1) m = 32'h80000000;
      if (i % 4 == 2) q = 32'h7FFFFFFF;
      launch_and_wait(m, q, 1'b0, e, bok, sok, h, l);
      n_cmp++;
      if ({h, l} !== model(m, q) || e !== LAT) begin
        n_bad++;
        $display("FAIL rnd%0d_product: got %h_%h lat %0d want %h lat %0d", i, h, l, e, model(m, q), LAT);
      end
      repeat (2) tick();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    clear_n = 1'b0;
    bif.start = 1'b0;
    bif.multiplicand = '0;
    bif.multiplier = '0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_clear_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
